// File: rtl/fp_div_iter.sv
// Iterative IEEE 754 single-precision divider: restoring radix-2 core,
// one quotient bit per cycle, truncating rounding, denormals flushed to zero.
module fp_div_iter #(
   parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        div_by_zero
);

   localparam int unsigned EXP_W    = 8;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned MANT_W   = FRAC_W + 1;
   localparam int unsigned REM_W    = MANT_W + 1;
   localparam int unsigned QUO_W    = 25;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned LAST_CNT = QUO_W - 1;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_e;

   state_e              state_q, state_d;
   logic                sign_q, sign_d;
   logic [EXP_W-1:0]    ea_q, ea_d, eb_q, eb_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [MANT_W-1:0]   dvs_q, dvs_d;
   logic [QUO_W-1:0]    quo_q, quo_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         res_q, res_d;
   logic                dbz_q, dbz_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   // Operand classification, evaluated on the raw inputs at acceptance
   logic a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;
   assign a_exp_max = (a[30:23] == 8'hFF);
   assign b_exp_max = (b[30:23] == 8'hFF);
   assign a_nan     = a_exp_max && (a[22:0] != 23'h0);
   assign b_nan     = b_exp_max && (b[22:0] != 23'h0);
   assign a_inf     = a_exp_max && (a[22:0] == 23'h0);
   assign b_inf     = b_exp_max && (b[22:0] == 23'h0);
   assign a_zero    = (a[30:23] == 8'h00);
   assign b_zero    = (b[30:23] == 8'h00);
   assign op_sign   = a[31] ^ b[31];

   // One restoring step: subtract divisor when it fits, then shift left
   logic [REM_W-1:0] dvs_ext, diff;
   logic             q_bit;
   assign dvs_ext = {1'b0, dvs_q};
   assign q_bit   = (rem_q >= dvs_ext);
   assign diff    = q_bit ? (rem_q - dvs_ext) : rem_q;

   // Normalisation: quotient lies in (0.5, 2), so at most one position of shift
   logic signed [9:0]   exp_s;
   logic [FRAC_W-1:0]   mant_n;
   assign exp_s  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                 + (quo_q[QUO_W-1] ? 10'sd127 : 10'sd126);
   assign mant_n = quo_q[QUO_W-1] ? quo_q[QUO_W-2:1] : quo_q[QUO_W-3:0];

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      ea_d    = ea_q;
      eb_d    = eb_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = op_sign;
               ea_d   = a[30:23];
               eb_d   = b[30:23];
               dbz_d  = 1'b0;
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  res_d   = NAN_VALUE;
                  state_d = DONE;
               end else if (a_inf) begin
                  res_d   = {op_sign, 8'hFF, 23'h0};
                  state_d = DONE;
               end else if (b_zero) begin
                  res_d   = {op_sign, 8'hFF, 23'h0};
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else if (a_zero || b_inf) begin
                  res_d   = 32'h0000_0000;
                  state_d = DONE;
               end else begin
                  rem_d   = {1'b0, 1'b1, a[22:0]};
                  dvs_d   = {1'b1, b[22:0]};
                  quo_d   = '0;
                  cnt_d   = '0;
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            quo_d = {quo_q[QUO_W-2:0], q_bit};
            rem_d = diff << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LAST_CNT)) begin
               state_d = NORM;
            end
         end
         NORM: begin
            if (exp_s >= 10'sd255) begin
               res_d = {sign_q, 8'hFF, 23'h0};
            end else if (exp_s <= 10'sd0) begin
               res_d = 32'h0000_0000;
            end else begin
               res_d = {sign_q, exp_s[EXP_W-1:0], mant_n};
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         ea_q        <= '0;
         eb_q        <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         ea_q        <= ea_d;
         eb_q        <= eb_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign result      = res_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: normal quotients, special cases,
// back-pressure and reset behaviour against hand-computed values.
module tb_fp_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_s, b_s;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] r_obs;
   logic        z_obs;
   int          lat_obs;
   bit          to_obs;

   always #5 clk = ~clk;

   fp_div_iter dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a_s),
      .b          (b_s),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .div_by_zero(div_by_zero)
   );

   // Normal-path vectors: dividend, divisor, expected quotient
   localparam int NN = 6;
   localparam logic [31:0] NA [NN] = '{32'h40C00000, 32'h3F800000, 32'hC1000000,
                                       32'h41200000, 32'h7F000000, 32'h00800000};
   localparam logic [31:0] NB [NN] = '{32'h40000000, 32'h40400000, 32'h3F000000,
                                       32'h40800000, 32'h3E800000, 32'h40000000};
   localparam logic [31:0] NR [NN] = '{32'h40400000, 32'h3EAAAAAA, 32'hC1800000,
                                       32'h40200000, 32'h7F800000, 32'h00000000};

   // Special-case vectors: dividend, divisor, expected result, expected div_by_zero
   localparam int NS = 13;
   localparam logic [31:0] SA [NS] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                                       32'h7FC00001, 32'h40000000, 32'hFF800000, 32'h7F800000,
                                       32'h00000000, 32'h40A00000, 32'hC0A00000, 32'h00000001,
                                       32'h3F800000};
   localparam logic [31:0] SB [NS] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'hFF800000,
                                       32'h40000000, 32'h7F800001, 32'h40000000, 32'h00000000,
                                       32'h40A00000, 32'h7F800000, 32'h7F800000, 32'h40000000,
                                       32'h00000001};
   localparam logic [31:0] SR [NS] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                                       32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                                       32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                                       32'h7F800000};
   localparam logic        SZ [NS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Issue one operation from a negedge, wait for the result, then consume it
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv);
      in_valid = 1'b1;
      a_s      = av;
      b_s      = bv;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat_obs  = 0;
      to_obs   = 1'b0;
      while (!out_valid && lat_obs < 100) begin
         @(posedge clk);
         lat_obs++;
         @(negedge clk);
      end
      if (!out_valid) to_obs = 1'b1;
      r_obs     = result;
      z_obs     = div_by_zero;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      a_s      = 32'h40C00000;
      b_s      = 32'h40000000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h dbz=%b, want 1 0 00000000 0",
                  in_ready, out_valid, result, div_by_zero);
      end
      // First edge with rst low and in_valid high must accept
      rst = 1'b0;
      a_s = 32'h3F800000;
      b_s = 32'h00000000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'h7F800000 || div_by_zero !== 1'b1) begin
         n_err++;
         $display("FAIL first_accept: out_valid=%b result=%h dbz=%b, want 1 7f800000 1",
                  out_valid, result, div_by_zero);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL pop_to_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_normal();
      for (int i = 0; i < NN; i++) begin
         run_op(NA[i], NB[i]);
         n_vec++;
         if (to_obs || r_obs !== NR[i] || z_obs !== 1'b0 || lat_obs !== 26) begin
            n_err++;
            $display("FAIL normal[%0d]: a=%h b=%h result=%h dbz=%b lat=%0d timeout=%b, want %h 0 26 0",
                     i, NA[i], NB[i], r_obs, z_obs, lat_obs, to_obs, NR[i]);
         end
      end
   endtask

   task automatic test_special();
      for (int i = 0; i < NS; i++) begin
         run_op(SA[i], SB[i]);
         n_vec++;
         if (to_obs || r_obs !== SR[i] || z_obs !== SZ[i] || lat_obs !== 0) begin
            n_err++;
            $display("FAIL special[%0d]: a=%h b=%h result=%h dbz=%b lat=%0d timeout=%b, want %h %b 0 0",
                     i, SA[i], SB[i], r_obs, z_obs, lat_obs, to_obs, SR[i], SZ[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int wait_n;
      in_valid = 1'b1;
      a_s      = 32'h40C00000;
      b_s      = 32'h40000000;
      @(posedge clk);
      @(negedge clk);
      // Offer a different request while busy; it must be ignored
      a_s    = 32'h3F800000;
      b_s    = 32'h00000000;
      wait_n = 0;
      while (!out_valid && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      n_vec++;
      if (!out_valid) begin
         n_err++;
         $display("FAIL bp_wait: out_valid=%b after %0d cycles, want 1", out_valid, wait_n);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h dbz=%b, want 1 0 40400000 0",
                     k, out_valid, in_ready, result, div_by_zero);
         end
      end
      // Release with in_valid still high: no acceptance on the take edge
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'h7F800000 || div_by_zero !== 1'b1) begin
         n_err++;
         $display("FAIL bp_next_accept: out_valid=%b result=%h dbz=%b, want 1 7f800000 1",
                  out_valid, result, div_by_zero);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_div();
      bit saw_valid;
      in_valid = 1'b1;
      a_s      = 32'h3F800000;
      b_s      = 32'h40400000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_div: in_ready=%b out_valid=%b result=%h dbz=%b, want 1 0 00000000 0",
                  in_ready, out_valid, result, div_by_zero);
      end
      saw_valid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      n_vec++;
      if (saw_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_discard: out_valid seen=%b after reset, want 0", saw_valid);
      end
      run_op(32'h40C00000, 32'h40000000);
      n_vec++;
      if (to_obs || r_obs !== 32'h40400000 || z_obs !== 1'b0 || lat_obs !== 26) begin
         n_err++;
         $display("FAIL rst_then_op: result=%h dbz=%b lat=%0d timeout=%b, want 40400000 0 26 0",
                  r_obs, z_obs, lat_obs, to_obs);
      end
   endtask

   task automatic test_reset_in_done();
      in_valid = 1'b1;
      a_s      = 32'hBF800000;
      b_s      = 32'h00000000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
         n_err++;
         $display("FAIL rst_in_done: in_ready=%b out_valid=%b result=%h dbz=%b, want 1 0 00000000 0",
                  in_ready, out_valid, result, div_by_zero);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_s       = '0;
      b_s       = '0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_special();
      test_backpressure();
      test_reset_mid_div();
      test_reset_in_done();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
